// File: rtl/rv32i_types.sv
// Shared types for the instruction-side line fill arbiter.
package rv32i_types;

    typedef enum logic [1:0] {IDLE, MEM_DMD, MEM_PF, RESP} arb_state_t;

    localparam int unsigned LINE_OFFSET_BITS = 5;

    localparam logic ARB_OWNER_DMD = 1'b0;
    localparam logic ARB_OWNER_PF  = 1'b1;

    localparam logic [31:0] LINE_OFFSET_MASK = (32'd1 << LINE_OFFSET_BITS) - 32'd1;

    // Clear the byte-in-line offset of an address.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~LINE_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/line_fill_arbiter.sv
// Line fill arbiter: shares one burst memory read port between the demand
// miss path and the next-line prefetcher. Demand has priority unless the
// prefetch has waited STARVE_LIMIT cycles. Define LINE_FWD_EN to let a
// demand to the line already being prefetched ride on that fill.
module line_fill_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned LINE_BITS    = 256,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dmd_read,
    input  logic [31:0]          dmd_addr,
    output logic [LINE_BITS-1:0] dmd_rdata,
    output logic                 dmd_resp,
    input  logic                 pf_read,
    input  logic [31:0]          pf_addr,
    output logic [LINE_BITS-1:0] pf_rdata,
    output logic                 pf_resp,
    output logic                 mem_read,
    output logic [31:0]          mem_addr,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_resp,
    output logic                 busy
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    arb_state_t           state_q, state_d;
    logic [7:0]           pf_wait_cnt_q, pf_wait_cnt_d;
    logic                 mem_read_d;
    logic [31:0]          mem_addr_d;
    logic                 dmd_resp_d, pf_resp_d, busy_d;
    logic [LINE_BITS-1:0] dmd_rdata_d, pf_rdata_d;
    logic                 grant_valid;
    logic                 grant_owner;
`ifdef LINE_FWD_EN
    logic                 merged_q, merged_d;
`endif

    // Next-state, grant decision and registered-output next values.
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read;
        mem_addr_d  = mem_addr;
        dmd_resp_d  = 1'b0;
        pf_resp_d   = 1'b0;
        dmd_rdata_d = dmd_rdata;
        pf_rdata_d  = pf_rdata;
        grant_valid = 1'b0;
        grant_owner = ARB_OWNER_DMD;
`ifdef LINE_FWD_EN
        merged_d    = merged_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef LINE_FWD_EN
                merged_d = 1'b0;
`endif
                if (pf_read && pf_wait_cnt_q == STARVE_MAX) begin
                    grant_valid = 1'b1;
                    grant_owner = ARB_OWNER_PF;
                end else if (dmd_read) begin
                    grant_valid = 1'b1;
                    grant_owner = ARB_OWNER_DMD;
                end else if (pf_read) begin
                    grant_valid = 1'b1;
                    grant_owner = ARB_OWNER_PF;
                end
                if (grant_valid) begin
                    mem_read_d = 1'b1;
                    if (grant_owner == ARB_OWNER_PF) begin
                        state_d    = MEM_PF;
                        mem_addr_d = line_align(pf_addr);
                    end else begin
                        state_d    = MEM_DMD;
                        mem_addr_d = line_align(dmd_addr);
                    end
                end
            end
            MEM_DMD: begin
                if (mem_resp) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    dmd_rdata_d = mem_rdata;
                    dmd_resp_d  = 1'b1;
                end
            end
            MEM_PF: begin
`ifdef LINE_FWD_EN
                // A demand for the in-flight line rides on this fill.
                if (dmd_read &&
                    line_align(dmd_addr) == line_align(mem_addr)) begin
                    merged_d = 1'b1;
                end
`endif
                if (mem_resp) begin
                    state_d    = RESP;
                    mem_read_d = 1'b0;
                    pf_rdata_d = mem_rdata;
                    pf_resp_d  = 1'b1;
`ifdef LINE_FWD_EN
                    if (merged_d) begin
                        dmd_rdata_d = mem_rdata;
                        dmd_resp_d  = 1'b1;
                    end
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef LINE_FWD_EN
                merged_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Prefetch starvation counter; a prefetch being served is not waiting.
    always_comb begin
        pf_wait_cnt_d = pf_wait_cnt_q;
        if (!pf_read || state_q == MEM_PF ||
            (grant_valid && grant_owner == ARB_OWNER_PF)) begin
            pf_wait_cnt_d = 8'd0;
        end else if (pf_wait_cnt_q != STARVE_MAX) begin
            pf_wait_cnt_d = pf_wait_cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            pf_wait_cnt_q <= 8'd0;
            mem_read      <= 1'b0;
            mem_addr      <= 32'd0;
            dmd_resp      <= 1'b0;
            pf_resp       <= 1'b0;
            dmd_rdata     <= '0;
            pf_rdata      <= '0;
            busy          <= 1'b0;
`ifdef LINE_FWD_EN
            merged_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pf_wait_cnt_q <= pf_wait_cnt_d;
            mem_read      <= mem_read_d;
            mem_addr      <= mem_addr_d;
            dmd_resp      <= dmd_resp_d;
            pf_resp       <= pf_resp_d;
            dmd_rdata     <= dmd_rdata_d;
            pf_rdata      <= pf_rdata_d;
            busy          <= busy_d;
`ifdef LINE_FWD_EN
            merged_q      <= merged_d;
`endif
        end
    end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed self-checking bench for line_fill_arbiter (STARVE_LIMIT = 2).
module tb_line_fill_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         dmd_read;
    logic [31:0]  dmd_addr;
    logic [255:0] dmd_rdata;
    logic         dmd_resp;
    logic         pf_read;
    logic [31:0]  pf_addr;
    logic [255:0] pf_rdata;
    logic         pf_resp;
    logic         mem_read;
    logic [31:0]  mem_addr;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] l1, l2, l3, l4, l5, l6;

    line_fill_arbiter #(
        .LINE_BITS    (256),
        .STARVE_LIMIT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dmd_read  (dmd_read),
        .dmd_addr  (dmd_addr),
        .dmd_rdata (dmd_rdata),
        .dmd_resp  (dmd_resp),
        .pf_read   (pf_read),
        .pf_addr   (pf_addr),
        .pf_rdata  (pf_rdata),
        .pf_resp   (pf_resp),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        l1 = {8{32'hA5A5_0001}};
        l2 = {8{32'h5A5A_0002}};
        l3 = {8{32'hC3C3_0003}};
        l4 = {8{32'h3C3C_0004}};
        l5 = {8{32'h0F0F_0005}};
        l6 = {8{32'hDEAD_0006}};

        rst = 1'b0; dmd_read = 1'b0; dmd_addr = 32'd0; pf_read = 1'b0; pf_addr = 32'd0;
        mem_rdata = '0; mem_resp = 1'b0;
        #1;
        tick(); tick();
        chk("rst_mem_read", 256'(mem_read), 256'd0);
        chk("rst_mem_addr", 256'(mem_addr), 256'd0);
        chk("rst_dmd_resp", 256'(dmd_resp), 256'd0);
        chk("rst_pf_resp", 256'(pf_resp), 256'd0);
        chk("rst_dmd_rdata", dmd_rdata, 256'd0);
        chk("rst_pf_rdata", pf_rdata, 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        rst = 1'b1;
        tick();

        // Demand only, memory answers 2 cycles after mem_read rises.
        dmd_read = 1'b1; dmd_addr = 32'h0000_1234;
        tick();
        chk("d1_mem_read", 256'(mem_read), 256'd1);
        chk("d1_mem_addr", 256'(mem_addr), 256'h0000_1220);
        chk("d1_busy", 256'(busy), 256'd1);
        tick();
        tick();
        chk("d1_mem_read_held", 256'(mem_read), 256'd1);
        mem_resp = 1'b1; mem_rdata = l1;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("d1_dmd_resp", 256'(dmd_resp), 256'd1);
        chk("d1_dmd_rdata", dmd_rdata, l1);
        chk("d1_pf_resp", 256'(pf_resp), 256'd0);
        chk("d1_mem_read_drop", 256'(mem_read), 256'd0);
        dmd_read = 1'b0;
        tick();
        chk("d1_resp_pulse", 256'(dmd_resp), 256'd0);
        chk("d1_idle", 256'(busy), 256'd0);
        chk("d1_rdata_hold", dmd_rdata, l1);

        // Both rise together: demand first, prefetch mem_read 3 cycles after mem_resp.
        dmd_read = 1'b1; dmd_addr = 32'h0000_0100;
        pf_read = 1'b1; pf_addr = 32'h0000_2044;
        tick();
        chk("b_dmd_addr", 256'(mem_addr), 256'h0000_0100);
        mem_resp = 1'b1; mem_rdata = l2;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("b_dmd_resp", 256'(dmd_resp), 256'd1);
        chk("b_pf_resp_low", 256'(pf_resp), 256'd0);
        dmd_read = 1'b0;
        tick();
        chk("b_gap_mem_read", 256'(mem_read), 256'd0);
        tick();
        chk("b_pf_mem_read", 256'(mem_read), 256'd1);
        chk("b_pf_mem_addr", 256'(mem_addr), 256'h0000_2040);
        mem_resp = 1'b1; mem_rdata = l3;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("b_pf_resp", 256'(pf_resp), 256'd1);
        chk("b_pf_rdata", pf_rdata, l3);
        chk("b_dmd_rdata_hold", dmd_rdata, l2);
        chk("b_dmd_resp_low", 256'(dmd_resp), 256'd0);
        pf_read = 1'b0;
        tick();

        // Starvation: the wait counter saturates at 2 during the first demand's
        // fill, so the held prefetch beats the next (pending) demand.
        dmd_read = 1'b1; dmd_addr = 32'h0000_4000;
        pf_read = 1'b1; pf_addr = 32'h0000_3000;
        tick();
        chk("s_dmd_first", 256'(mem_addr), 256'h0000_4000);
        mem_resp = 1'b1; mem_rdata = l4;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("s_dmd_resp", 256'(dmd_resp), 256'd1);
        dmd_addr = 32'h0000_5000;
        tick();
        tick();
        chk("s_pf_wins", 256'(mem_addr), 256'h0000_3000);
        chk("s_pf_mem_read", 256'(mem_read), 256'd1);
        mem_resp = 1'b1; mem_rdata = l5;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("s_pf_resp", 256'(pf_resp), 256'd1);
        chk("s_dmd_resp_low", 256'(dmd_resp), 256'd0);
        pf_read = 1'b0;
        tick();
        tick();
        chk("s_dmd_next", 256'(mem_addr), 256'h0000_5000);
        mem_resp = 1'b1; mem_rdata = l6;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("s_dmd2_rdata", dmd_rdata, l6);
        dmd_read = 1'b0;
        tick();

        // Same-line demand while a prefetch of 0x40 is in flight.
        pf_read = 1'b1; pf_addr = 32'h0000_0040;
        tick();
        chk("f_pf_addr", 256'(mem_addr), 256'h0000_0040);
        dmd_read = 1'b1; dmd_addr = 32'h0000_0044;
        tick();
        mem_resp = 1'b1; mem_rdata = l1;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("f_pf_resp", 256'(pf_resp), 256'd1);
        chk("f_pf_rdata", pf_rdata, l1);
        pf_read = 1'b0;
`ifdef LINE_FWD_EN
        chk("f_dmd_resp_merged", 256'(dmd_resp), 256'd1);
        chk("f_dmd_rdata_merged", dmd_rdata, l1);
        dmd_read = 1'b0;
        tick();
        tick();
        chk("f_no_second_read", 256'(mem_read), 256'd0);
`else
        chk("f_dmd_resp_separate", 256'(dmd_resp), 256'd0);
        tick();
        tick();
        chk("f_second_read", 256'(mem_read), 256'd1);
        chk("f_second_addr", 256'(mem_addr), 256'h0000_0040);
        mem_resp = 1'b1; mem_rdata = l2;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("f_dmd_rdata", dmd_rdata, l2);
        dmd_read = 1'b0;
        tick();
`endif

        // Reset mid MEM_DMD abandons the read and clears the data registers.
        dmd_read = 1'b1; dmd_addr = 32'h0000_0080;
        tick();
        chk("r_mem_read", 256'(mem_read), 256'd1);
        rst = 1'b0;
        tick();
        chk("r_mem_read_clr", 256'(mem_read), 256'd0);
        chk("r_busy_clr", 256'(busy), 256'd0);
        chk("r_dmd_rdata_clr", dmd_rdata, 256'd0);
        chk("r_pf_rdata_clr", pf_rdata, 256'd0);
        rst = 1'b1; dmd_read = 1'b0;
        tick();
        mem_resp = 1'b1; mem_rdata = l3;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        tick();
        chk("r_stray_dmd_resp", 256'(dmd_resp), 256'd0);
        chk("r_stray_pf_resp", 256'(pf_resp), 256'd0);
        chk("r_stray_busy", 256'(busy), 256'd0);

        // mem_resp while IDLE is ignored.
        mem_resp = 1'b1; mem_rdata = l4;
        tick();
        mem_resp = 1'b0; mem_rdata = '0;
        chk("i_busy", 256'(busy), 256'd0);
        chk("i_mem_read", 256'(mem_read), 256'd0);
        chk("i_dmd_rdata", dmd_rdata, 256'd0);
        tick();
        chk("i_dmd_resp", 256'(dmd_resp), 256'd0);
        chk("i_pf_resp", 256'(pf_resp), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
